link_loopback_bist: RTL and testbench

Single-clock built-in self-test engine for the SPI-coax link, parametrised in word width, channel count and outstanding depth. It sits in the `clk_sys` domain at system top level and sources the encoder's payload stream in place of sensor data. It then checks the decoder's recovered words in order against a locally regenerated copy, and reports counts, the first mismatch, timeouts and an overall pass/fail.

---
 rtl/link_loopback_bist.sv | 144 ++++++++++++++
 tb/tb_link_loopback_bist.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/link_loopback_bist.sv
// link_loopback_bist: link BIST that sources a counter/PRBS word stream and checks the looped-back words in order.
module link_loopback_bist #(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 4,
  parameter int MAX_OUT = 16,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [CNT_W-1:0]  num_words,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic [CNT_W-1:0]  rcvd_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int PW = DATA_W - CH_W;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic mode_r, have_err, go, hs, rx_act, spur, good, err, to_hit, tx_valid_d;
  logic [CNT_W-1:0] num_r, sent_d;
  logic [7:0] outst, out_d;
  logic [TW-1:0] timer;
  logic [CH_W-1:0] tx_ch, rx_ch;
  logic [PW-1:0] tx_fr, rx_fr;
  logic [31:0] tx_lf, rx_lf;
  logic [DATA_W-1:0] rx_word;
  // x^32+x^22+x^2+x+1, shifting towards the MSB
  function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  assign tx_data = {tx_ch, mode_r ? tx_lf[PW-1:0] : tx_fr};
  assign rx_word = {rx_ch, mode_r ? rx_lf[PW-1:0] : rx_fr};
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign pass = done && err_cnt == '0 && !timeout_err;
  always_comb begin
    go = start && !abort && (state == IDLE || state == DONE);
    hs = tx_valid && tx_ready;
    rx_act = rx_valid && busy;
    spur = rx_act && outst == '0;
    good = rx_act && outst != '0;
    err = spur || (good && rx_data != rx_word);
    to_hit = busy && outst != '0 && !rx_valid && timer == TW'(TIMEOUT - 1);
    sent_d = hs ? sat(sent_cnt) : sent_cnt;
    out_d = hs && !good ? outst + 8'd1 : good && !hs ? outst - 8'd1 : outst;
    state_d = state;
    if (abort) state_d = IDLE;
    else if (go) state_d = num_words == '0 ? DONE : RUN;
    else if (to_hit) state_d = DONE;
    else if (state == RUN && sent_cnt == num_r) state_d = DRAIN;
    else if (state == DRAIN && outst == '0) state_d = DONE;
    tx_valid_d = state_d == RUN && (go || (sent_d < num_r && out_d < 8'(MAX_OUT)));
  end
  always_ff @(posedge clk_sys) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      mode_r <= 1'b0;
      num_r <= '0;
      sent_cnt <= '0;
      rcvd_cnt <= '0;
      err_cnt <= '0;
      outst <= '0;
      timer <= '0;
      timeout_err <= 1'b0;
      have_err <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
      tx_ch <= '0;
      tx_fr <= '0;
      tx_lf <= 32'h1;
      rx_ch <= '0;
      rx_fr <= '0;
      rx_lf <= 32'h1;
    end else begin
      tx_valid <= tx_valid_d;
      if (go) begin
        mode_r <= mode;
        num_r <= num_words;
        sent_cnt <= '0;
        rcvd_cnt <= '0;
        err_cnt <= '0;
        outst <= '0;
        timer <= '0;
        timeout_err <= 1'b0;
        have_err <= 1'b0;
        first_err_exp <= '0;
        first_err_got <= '0;
        tx_ch <= '0;
        tx_fr <= '0;
        tx_lf <= 32'h1;
        rx_ch <= '0;
        rx_fr <= '0;
        rx_lf <= 32'h1;
      end else begin
        sent_cnt <= sent_d;
        outst <= out_d;
        timer <= (!busy || rx_valid || outst == '0) ? '0 : timer + 1'b1;
        if (to_hit && !abort) timeout_err <= 1'b1;
        if (hs) begin
          tx_ch <= tx_ch == CH_LAST ? '0 : tx_ch + 1'b1;
          tx_fr <= tx_fr + PW'(tx_ch == CH_LAST);
          tx_lf <= lfsr_nx(tx_lf);
        end
        // a spurious word has no slot in the expected stream, so the RX generator holds
        if (good) begin
          rx_ch <= rx_ch == CH_LAST ? '0 : rx_ch + 1'b1;
          rx_fr <= rx_fr + PW'(rx_ch == CH_LAST);
          rx_lf <= lfsr_nx(rx_lf);
        end
        if (rx_act) rcvd_cnt <= sat(rcvd_cnt);
        if (err) err_cnt <= sat(err_cnt);
        if (err && !have_err) begin
          have_err <= 1'b1;
          first_err_exp <= spur ? '0 : rx_word;
          first_err_got <= rx_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_link_loopback_bist.sv
// tb_link_loopback_bist: scoreboard bench; TX words are checked against a queue filled at start, run results against hand values.
module tb_link_loopback_bist;
  localparam int DW = 32, NC = 4, MO = 16, TO = 64, CW = 16;
  logic clk_sys = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic tx_ready = 1'b0, rx_valid = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic [DW-1:0] rx_data = '0;
  logic [DW-1:0] tx_data, first_err_exp, first_err_got;
  logic tx_valid, busy, done, pass, timeout_err;
  logic [CW-1:0] sent_cnt, rcvd_cnt, err_cnt;
  link_loopback_bist #(.DATA_W(DW), .NUM_CH(NC), .MAX_OUT(MO), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .num_words(num_words), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .pass(pass),
    .timeout_err(timeout_err), .sent_cnt(sent_cnt), .rcvd_cnt(rcvd_cnt), .err_cnt(err_cnt),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );
  always #5 clk_sys = ~clk_sys;
  typedef struct {int due; logic [31:0] d;} ent_t;
  ent_t pipe[$];
  logic [31:0] exp_q[$];
  logic [31:0] expw[256];
  logic [31:0] cap[256];
  int total = 0, bad = 0;
  int cyc = 0, hs_n = 0, out_m = 0, mx = 0, cidx = -1, drop_from = 0, dly = 1, bp = 0;
  int last_rx = -1, to_cyc = -1, mon_n = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask
  // one cycle of loopback: drive ready/rx at the falling edge for the next rising edge
  task automatic tick(input bit spur = 1'b0);
    logic [31:0] d;
    ent_t e;
    int o;
    @(negedge clk_sys);
    cyc++;
    tx_ready = bp == 0 ? 1'b1 : bp == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    o = out_m;
    if (tx_valid && tx_ready) begin
      d = tx_data;
      if (hs_n == cidx) d[0] = ~d[0];
      if (hs_n < drop_from) begin
        e.due = cyc + dly;
        e.d = d;
        pipe.push_back(e);
      end
      hs_n++;
      out_m++;
    end
    rx_valid = 1'b0;
    if (spur) begin
      rx_valid = 1'b1;
      rx_data = 32'hDEAD_BEEF;
    end else if (pipe.size() > 0 && pipe[0].due == cyc) begin
      e = pipe.pop_front();
      rx_valid = 1'b1;
      rx_data = e.d;
      last_rx = cyc;
    end
    if (rx_valid && o > 0) out_m--;
    if (out_m > mx) mx = out_m;
  endtask
  task automatic monitor();
    bit stall = 1'b0;
    logic [31:0] held, w;
    forever begin
      @(posedge clk_sys);
      if (stall && tx_valid) chk("tx_stable", tx_data, held);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_extra_word: got %0h expected no word", tx_data);
        end else begin
          w = exp_q.pop_front();
          chk($sformatf("tx_word%0d", mon_n), tx_data, w);
        end
        if (mon_n < 256) cap[mon_n] = tx_data;
        mon_n++;
      end
      stall = tx_valid && !tx_ready;
      held = tx_data;
    end
  endtask
  task automatic all_zero(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_pass"}, pass, 0);
    chk({p, "_timeout"}, timeout_err, 0);
    chk({p, "_tx_valid"}, tx_valid, 0);
    chk({p, "_tx_data"}, tx_data, 0);
    chk({p, "_sent"}, sent_cnt, 0);
    chk({p, "_rcvd"}, rcvd_cnt, 0);
    chk({p, "_err"}, err_cnt, 0);
    chk({p, "_fe_exp"}, first_err_exp, 0);
    chk({p, "_fe_got"}, first_err_got, 0);
  endtask
  task automatic launch(input bit m, input int n, input int d, input int b, input int ci, input int dr);
    logic [31:0] lf, w;
    pipe.delete();
    exp_q.delete();
    hs_n = 0;
    out_m = 0;
    mx = 0;
    mon_n = 0;
    cidx = ci;
    drop_from = n - dr;
    dly = d;
    bp = b;
    to_cyc = -1;
    last_rx = -1;
    lf = 32'h1;
    for (int i = 0; i < n; i++) begin
      w = {2'(i % 4), m ? lf[29:0] : 30'(i / 4)};
      exp_q.push_back(w);
      if (i < 256) expw[i] = w;
      lf = {lf[30:0], lf[31] ^ lf[21] ^ lf[1] ^ lf[0]};
    end
    mode = m;
    num_words = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_tx_valid", tx_valid, 1);
    chk("start_word0", tx_data, expw[0]);
  endtask
  task automatic wait_done();
    int k;
    for (k = 0; k < 6000 && !done; k++) begin
      tick();
      if (timeout_err && to_cyc < 0) to_cyc = cyc;
    end
    rx_valid = 1'b0;
    chk("run_done", done, 1);
  endtask
  initial begin
    fork
      monitor();
    join_none
    repeat (3) tick();
    all_zero("reset");
    rst_n = 1'b1;
    tick();
    launch(1'b0, 100, 5, 0, -1, 0);
    wait_done();
    chk("clean_pass", pass, 1);
    chk("clean_sent", sent_cnt, 100);
    chk("clean_rcvd", rcvd_cnt, 100);
    chk("clean_err", err_cnt, 0);
    chk("clean_word5", cap[5], 32'h4000_0001);
    chk("clean_word7", cap[7], 32'hC000_0001);
    chk("clean_drained", exp_q.size(), 0);
    launch(1'b1, 60, 5, 0, 37, 0);
    wait_done();
    chk("prbs_word0", cap[0], 32'h0000_0001);
    chk("prbs_word1", cap[1], 32'h4000_0003);
    chk("prbs_word2", cap[2], 32'h8000_0006);
    chk("prbs_word3", cap[3], 32'hC000_000D);
    chk("corrupt_err", err_cnt, 1);
    chk("corrupt_fe_exp", first_err_exp, expw[37]);
    chk("corrupt_fe_got", first_err_got, expw[37] ^ 32'h1);
    chk("corrupt_pass", pass, 0);
    launch(1'b0, 200, 40, 1, -1, 0);
    wait_done();
    chk("bp_max_outstanding", mx, MO);
    chk("bp_rcvd", rcvd_cnt, 200);
    chk("bp_pass", pass, 1);
    chk("bp_drained", exp_q.size(), 0);
    launch(1'b0, 40, 5, 0, -1, 3);
    wait_done();
    chk("lost_timeout", timeout_err, 1);
    chk("lost_timeout_edges", to_cyc - last_rx, TO + 1);
    chk("lost_sent", sent_cnt, 40);
    chk("lost_rcvd", rcvd_cnt, 37);
    chk("lost_pass", pass, 0);
    num_words = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_pass", pass, 1);
    chk("zero_busy", busy, 0);
    chk("zero_tx_valid", tx_valid, 0);
    launch(1'b0, 10, 5, 2, -1, 0);
    tick(1'b1);
    tick();
    chk("spur_err", err_cnt, 1);
    chk("spur_fe_exp", first_err_exp, 0);
    chk("spur_fe_got", first_err_got, 32'hDEAD_BEEF);
    chk("spur_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_keeps_err", err_cnt, 1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_done", done, 0);
    chk("start_abort_tx_valid", tx_valid, 0);
    launch(1'b0, 20, 5, 0, -1, 0);
    for (int k = 0; k < 200 && sent_cnt != 20; k++) tick();
    tick();
    chk("drain_sent", sent_cnt, 20);
    chk("drain_busy", busy, 1);
    chk("drain_tx_valid", tx_valid, 0);
    rst_n = 1'b0;
    tick();
    all_zero("rst_drain");
    rst_n = 1'b1;
    pipe.delete();
    tick();
    rx_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
